// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Bundle of the two requester ports (A = pipeline MEM stage,
//               B = debug/loader) and the DataMemory command/response port
//               served by dmem_arbiter.
//               Requester A/B : *_req, *_wr, *_addr, *_wd  -> arbiter
//                               *_ack, *_rd, *_err         <- arbiter
//               Memory        : mr, mw, addr, wd           <- arbiter
//                               rd                         -> arbiter
//               Status        : busy                       <- arbiter
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if;

  // Port A (pipeline MEM stage)
  logic        a_req;
  logic        a_wr;
  logic [31:0] a_addr;
  logic [31:0] a_wd;
  logic        a_ack;
  logic [31:0] a_rd;
  logic        a_err;

  // Port B (debug / loader)
  logic        b_req;
  logic        b_wr;
  logic [31:0] b_addr;
  logic [31:0] b_wd;
  logic        b_ack;
  logic [31:0] b_rd;
  logic        b_err;

  // DataMemory command / response
  logic        mr;
  logic        mw;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;

  logic        busy;

  // Arbiter side
  modport slave (
    input  a_req, a_wr, a_addr, a_wd,
    output a_ack, a_rd, a_err,
    input  b_req, b_wr, b_addr, b_wd,
    output b_ack, b_rd, b_err,
    output mr, mw, addr, wd,
    input  rd,
    output busy
  );

  // Environment side (requesters plus memory)
  modport master (
    output a_req, a_wr, a_addr, a_wd,
    input  a_ack, a_rd, a_err,
    output b_req, b_wr, b_addr, b_wd,
    input  b_ack, b_rd, b_err,
    input  mr, mw, addr, wd,
    output rd,
    input  busy
  );

endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin arbiter and sequencer for the shared DataMemory.
//               Accepts one access at a time from port A or port B, issues
//               a registered memory command for one cycle, then returns a
//               one-cycle acknowledge with read data and an error flag.
//               Misaligned or out-of-range addresses are acknowledged with
//               the error flag set and never reach the memory.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - dmem_arbiter_if.slave (requesters + memory port)
// Parameters  : MEM_WORDS - number of 32-bit words in DataMemory
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int MEM_WORDS = 256
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam logic [1:0]  C_IDLE      = 2'd0;
  localparam logic [1:0]  C_ISSUE     = 2'd1;
  localparam logic [1:0]  C_ACK       = 2'd2;
  localparam logic [31:0] C_MEM_WORDS = 32'(MEM_WORDS);

  logic [1:0]  r_state;
  logic        r_prio_b;   // 1: B wins the next contention, 0: A wins
  logic        r_win_b;    // owner of the access in flight
  logic        r_err;      // address check result of the access in flight
  logic        r_mr;
  logic        r_mw;
  logic [31:0] r_addr;
  logic [31:0] r_wd;
  logic [31:0] r_rdata;
  logic        r_a_ack;
  logic        r_b_ack;
  logic        r_a_err;
  logic        r_b_err;

  logic        w_start;
  logic        w_grant_b;
  logic        w_wr;
  logic [31:0] w_addr;
  logic [31:0] w_wd;
  logic        w_err;

  assign w_start   = (r_state == C_IDLE) && (bus.a_req || bus.b_req);
  // B wins when it is alone, or when both request and B holds priority.
  assign w_grant_b = bus.b_req && (!bus.a_req || r_prio_b);

  assign w_wr   = w_grant_b ? bus.b_wr   : bus.a_wr;
  assign w_addr = w_grant_b ? bus.b_addr : bus.a_addr;
  assign w_wd   = w_grant_b ? bus.b_wd   : bus.a_wd;

  // Word index is compared zero-extended to avoid a width mismatch.
  assign w_err  = (w_addr[1:0] != 2'b00) ||
                  ({2'b00, w_addr[31:2]} >= C_MEM_WORDS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= C_IDLE;
      r_prio_b <= 1'b0;
      r_win_b  <= 1'b0;
      r_err    <= 1'b0;
      r_mr     <= 1'b0;
      r_mw     <= 1'b0;
      r_addr   <= 32'h0;
      r_wd     <= 32'h0;
      r_rdata  <= 32'h0;
      r_a_ack  <= 1'b0;
      r_b_ack  <= 1'b0;
      r_a_err  <= 1'b0;
      r_b_err  <= 1'b0;
    end else begin
      case (r_state)
        C_IDLE: begin
          if (w_start) begin
            r_state  <= C_ISSUE;
            // The port just served drops to lowest priority.
            r_prio_b <= ~w_grant_b;
            r_win_b  <= w_grant_b;
            r_err    <= w_err;
            r_mr     <= ~w_wr & ~w_err;
            r_mw     <=  w_wr & ~w_err;
            r_addr   <= w_addr;
            r_wd     <= w_wd;
          end
        end

        C_ISSUE: begin
          r_state <= C_ACK;
          r_mr    <= 1'b0;
          r_mw    <= 1'b0;
          r_addr  <= 32'h0;
          r_wd    <= 32'h0;
          // Only a real read returns memory data; writes and errors return 0.
          r_rdata <= r_mr ? bus.rd : 32'h0;
          r_a_ack <= ~r_win_b;
          r_b_ack <=  r_win_b;
          r_a_err <= ~r_win_b & r_err;
          r_b_err <=  r_win_b & r_err;
        end

        C_ACK: begin
          r_state <= C_IDLE;
          r_rdata <= 32'h0;
          r_a_ack <= 1'b0;
          r_b_ack <= 1'b0;
          r_a_err <= 1'b0;
          r_b_err <= 1'b0;
        end

        default: begin
          r_state <= C_IDLE;
        end
      endcase
    end
  end

  assign bus.mr    = r_mr;
  assign bus.mw    = r_mw;
  assign bus.addr  = r_addr;
  assign bus.wd    = r_wd;

  assign bus.a_ack = r_a_ack;
  assign bus.b_ack = r_b_ack;
  assign bus.a_err = r_a_err;
  assign bus.b_err = r_b_err;
  // One response register serves both ports; the Ack says whose it is.
  assign bus.a_rd  = r_rdata;
  assign bus.b_rd  = r_rdata;

  assign bus.busy  = (r_state != C_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter with a 256-word
//               DataMemory model. Memory word i starts as 32'hC0DE0000 + i.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] mem [256];

  dmem_arbiter_if bus ();

  dmem_arbiter #(.MEM_WORDS(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DataMemory model: combinational read, write on the rising edge.
  assign bus.rd = bus.mr ? mem[bus.addr[9:2]] : 32'h0;
  always @(posedge clk) begin
    if (bus.mw) mem[bus.addr[9:2]] <= bus.wd;
  end

  // Values captured by access()
  logic        cap_mr, cap_mw, cap_busy_iss, cap_ack_iss;
  logic [31:0] cap_addr, cap_wd;
  logic        cap_ack, cap_other_ack, cap_err;
  logic [31:0] cap_rd;
  logic        cap_ack_after, cap_busy_after;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit port_b, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
    if (port_b) begin
      bus.b_req = 1'b1; bus.b_wr = wr; bus.b_addr = a; bus.b_wd = d;
    end else begin
      bus.a_req = 1'b1; bus.a_wr = wr; bus.a_addr = a; bus.a_wd = d;
    end
  endtask

  // Single uncontended access, started from a negedge with the arbiter idle.
  task automatic access(input bit port_b, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
    set_req(port_b, wr, a, d);
    @(negedge clk);                       // ISSUE
    cap_mr       = bus.mr;
    cap_mw       = bus.mw;
    cap_addr     = bus.addr;
    cap_wd       = bus.wd;
    cap_busy_iss = bus.busy;
    cap_ack_iss  = port_b ? bus.b_ack : bus.a_ack;
    @(negedge clk);                       // ACK
    cap_ack       = port_b ? bus.b_ack : bus.a_ack;
    cap_other_ack = port_b ? bus.a_ack : bus.b_ack;
    cap_err       = port_b ? bus.b_err : bus.a_err;
    cap_rd        = port_b ? bus.b_rd  : bus.a_rd;
    if (port_b) bus.b_req = 1'b0; else bus.a_req = 1'b0;
    @(negedge clk);                       // back in IDLE
    cap_ack_after  = port_b ? bus.b_ack : bus.a_ack;
    cap_busy_after = bus.busy;
  endtask

  initial begin
    logic [11:0] a_hist;
    logic [11:0] b_hist;
    logic [31:0] a_seen;
    logic [31:0] b_seen;
    logic        any_ack;

    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE0000 + 32'(i);
    bus.a_req = 1'b0; bus.a_wr = 1'b0; bus.a_addr = 32'h0; bus.a_wd = 32'h0;
    bus.b_req = 1'b0; bus.b_wr = 1'b0; bus.b_addr = 32'h0; bus.b_wd = 32'h0;
    rst = 1'b1;

    // ---- reset values
    repeat (2) @(negedge clk);
    chk("rst_mr",    32'(bus.mr),    32'h0);
    chk("rst_mw",    32'(bus.mw),    32'h0);
    chk("rst_addr",  bus.addr,       32'h0);
    chk("rst_wd",    bus.wd,         32'h0);
    chk("rst_ack",   {30'h0, bus.a_ack, bus.b_ack}, 32'h0);
    chk("rst_rd",    bus.a_rd | bus.b_rd, 32'h0);
    chk("rst_err",   {30'h0, bus.a_err, bus.b_err}, 32'h0);
    chk("rst_busy",  32'(bus.busy),  32'h0);
    rst = 1'b0;

    // ---- contention from the first IDLE after reset: A first, B 3 cycles later
    set_req(1'b0, 1'b0, 32'h8, 32'h0);
    set_req(1'b1, 1'b0, 32'hC, 32'h0);
    @(negedge clk);
    chk("cont_iss_addr_a", bus.addr, 32'h8);
    chk("cont_iss_mr",     32'(bus.mr), 32'h1);
    @(negedge clk);
    chk("cont_a_ack", {30'h0, bus.a_ack, bus.b_ack}, 32'h2);
    chk("cont_a_rd",  bus.a_rd, 32'hC0DE0002);
    bus.a_req = 1'b0;
    @(negedge clk);
    chk("cont_idle_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    chk("cont_iss_addr_b", bus.addr, 32'hC);
    @(negedge clk);
    chk("cont_b_ack", {30'h0, bus.a_ack, bus.b_ack}, 32'h1);
    chk("cont_b_rd",  bus.b_rd, 32'hC0DE0003);
    bus.b_req = 1'b0;
    @(negedge clk);

    // ---- held requests alternate A, B, A, B with Acks 3 cycles apart
    set_req(1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 32'h4, 32'h0);
    a_hist = '0; b_hist = '0; a_seen = '0; b_seen = '0; any_ack = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a_hist[i] = bus.a_ack;
      b_hist[i] = bus.b_ack;
      if (bus.a_ack && bus.b_ack) any_ack = 1'b1;
      if (bus.a_ack) a_seen = bus.a_rd;
      if (bus.b_ack) b_seen = bus.b_rd;
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    chk("alt_a_pattern", 32'(a_hist), 32'h082);
    chk("alt_b_pattern", 32'(b_hist), 32'h410);
    chk("alt_both_ack",  32'(any_ack), 32'h0);
    chk("alt_a_rd",      a_seen, 32'hC0DE0000);
    chk("alt_b_rd",      b_seen, 32'hC0DE0001);
    @(negedge clk);

    // ---- A write 0x10 <- DEADBEEF, then A read 0x10
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    chk("aw_iss_mw",   32'(cap_mw),   32'h1);
    chk("aw_iss_mr",   32'(cap_mr),   32'h0);
    chk("aw_iss_addr", cap_addr,      32'h10);
    chk("aw_iss_wd",   cap_wd,        32'hDEADBEEF);
    chk("aw_iss_busy", 32'(cap_busy_iss), 32'h1);
    chk("aw_ack",      32'(cap_ack),  32'h1);
    chk("aw_rd_zero",  cap_rd,        32'h0);
    access(1'b0, 1'b0, 32'h10, 32'h0);
    chk("ar_iss_mr",      32'(cap_mr),      32'h1);
    chk("ar_ack_early",   32'(cap_ack_iss), 32'h0);
    chk("ar_ack",         32'(cap_ack),     32'h1);
    chk("ar_other_ack",   32'(cap_other_ack), 32'h0);
    chk("ar_rd",          cap_rd,           32'hDEADBEEF);
    chk("ar_err",         32'(cap_err),     32'h0);
    chk("ar_ack_after",   32'(cap_ack_after), 32'h0);
    chk("ar_busy_after",  32'(cap_busy_after), 32'h0);

    // ---- B write/read at the last word
    access(1'b1, 1'b1, 32'h3FC, 32'h12345678);
    chk("bw_iss_mw",  32'(cap_mw), 32'h1);
    chk("bw_ack",     32'(cap_ack), 32'h1);
    access(1'b1, 1'b0, 32'h3FC, 32'h0);
    chk("br_ack",     32'(cap_ack), 32'h1);
    chk("br_rd",      cap_rd,       32'h12345678);
    chk("br_err",     32'(cap_err), 32'h0);

    // ---- out-of-range write and misaligned read
    access(1'b0, 1'b1, 32'h400, 32'hFFFF0000);
    chk("oor_iss_cmd", {30'h0, cap_mr, cap_mw}, 32'h0);
    chk("oor_ack",     32'(cap_ack), 32'h1);
    chk("oor_err",     32'(cap_err), 32'h1);
    chk("oor_rd",      cap_rd,       32'h0);
    access(1'b0, 1'b0, 32'h13, 32'h0);
    chk("mis_iss_cmd", {30'h0, cap_mr, cap_mw}, 32'h0);
    chk("mis_ack",     32'(cap_ack), 32'h1);
    chk("mis_err",     32'(cap_err), 32'h1);
    chk("mis_rd",      cap_rd,       32'h0);
    access(1'b0, 1'b0, 32'h0, 32'h0);
    chk("unch_rd",     cap_rd,       32'hC0DE0000);
    chk("unch_err",    32'(cap_err), 32'h0);

    // ---- reset during ISSUE of a write
    set_req(1'b0, 1'b1, 32'h20, 32'hAAAA5555);
    @(negedge clk);
    chk("rmid_iss_mw", 32'(bus.mw), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("rmid_mw",   32'(bus.mw),   32'h0);
    chk("rmid_mr",   32'(bus.mr),   32'h0);
    chk("rmid_addr", bus.addr,      32'h0);
    chk("rmid_wd",   bus.wd,        32'h0);
    chk("rmid_busy", 32'(bus.busy), 32'h0);
    bus.a_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    any_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.a_ack || bus.b_ack) any_ack = 1'b1;
    end
    chk("rmid_no_ack", 32'(any_ack), 32'h0);

    // Contention after reset: A first, and 0x20 still holds its old word.
    set_req(1'b0, 1'b0, 32'h20, 32'h0);
    set_req(1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk("post_iss_addr_a", bus.addr, 32'h20);
    @(negedge clk);
    chk("post_a_ack", {30'h0, bus.a_ack, bus.b_ack}, 32'h2);
    chk("post_a_rd",  bus.a_rd, 32'hC0DE0008);
    bus.a_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_iss_addr_b", bus.addr, 32'h10);
    @(negedge clk);
    chk("post_b_ack", {30'h0, bus.a_ack, bus.b_ack}, 32'h1);
    chk("post_b_rd",  bus.b_rd, 32'hDEADBEEF);
    bus.b_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
